// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants and the select-range helper for stream_demux.
package stream_demux_pkg;
    localparam int CNT_W  = 16;
    localparam int MAX_CH = 16;

    function automatic logic sel_valid(input logic [31:0] sel, input int unsigned n_ch);
        return sel < n_ch;
    endfunction
endpackage

// File: rtl/demux_ch_buf.sv
// demux_ch_buf: one-entry output buffer for a single demux channel.
// STREAM_DEMUX_CNT_EN adds a wrapping per-channel handshake counter.
module demux_ch_buf
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt
`endif
);

    // A write in the same cycle as a drain keeps valid high, so there is no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (wr_en) begin
            valid <= 1'b1;
            data  <= wr_data;
        end else if (valid && rd_ready) begin
            valid <= 1'b0;
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (valid && rd_ready) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-N valid/ready demultiplexer with one buffer per channel.
// STREAM_DEMUX_CNT_EN adds beat_cnt (per channel) and drop_cnt ports.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data,
    input  logic [SEL_W-1:0]       s_sel,
    output logic [N_CH-1:0]        m_valid,
    input  logic [N_CH-1:0]        m_ready,
    output logic [N_CH*DATA_W-1:0] m_data,
    output logic                   sel_err
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]  beat_cnt,
    output logic [CNT_W-1:0]       drop_cnt
`endif
);

    logic [N_CH-1:0] wr_en;
    logic            sel_ok;

    assign sel_ok = sel_valid(32'(s_sel), N_CH);

    // Out-of-range selects match no channel, so the default accepts and drops them.
    always_comb begin
        s_ready = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (s_sel == SEL_W'(k)) begin
                s_ready = ~m_valid[k] | m_ready[k];
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign wr_en[k] = s_valid && s_ready && (s_sel == SEL_W'(k));

        demux_ch_buf #(
            .DATA_W (DATA_W)
        ) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en[k]),
            .wr_data  (s_data),
            .rd_ready (m_ready[k]),
            .valid    (m_valid[k]),
            .data     (m_data[k*DATA_W +: DATA_W])
`ifdef STREAM_DEMUX_CNT_EN
            ,
            .cnt      (beat_cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= s_valid && !sel_ok;
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (s_valid && !sel_ok) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-N stream demultiplexer with a valid/ready handshake. It replaces the single-bit 1:2 combinational demux in datapaths that need backpressure. Each beat on the input stream carries a channel select and is steered into a one-entry output buffer for that channel. The block sits between a single producer and N independent consumers, with optional per-channel beat counters.

## Interface
Parameters:
- DATA_W, 8: payload width in bits (≥1)
- N_CH, 4: number of output channels (2..16; need not be a power of two)
- SEL_W, $clog2(N_CH): select width (derived; do not override)

Ports:
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  DATA_W  input payload
- s_sel  in  SEL_W  destination channel
- m_valid  out  N_CH  per-channel output valid
- m_ready  in  N_CH  per-channel consumer ready
- m_data  out  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- sel_err  out  1  one-cycle pulse when a beat with s_sel ≥ N_CH is accepted

## Operation
- Each channel k has a one-entry buffer: full flag f[k] and data register d[k]. m_valid[k] = f[k] and m_data slice k = d[k].
- Valid select (s_sel < N_CH):
  - s_ready = ~f[s_sel] | m_ready[s_sel].
  - On acceptance, d[s_sel] ← s_data and f[s_sel] ← 1.
- Invalid select (s_sel ≥ N_CH): s_ready = 1. The beat is accepted and dropped, and sel_err is registered high for the following cycle only.
- Drain: when f[k] & m_ready[k] and channel k is not written in that cycle, f[k] ← 0.
- Simultaneous drain and write on the same channel: f[k] stays 1, d[k] takes the new beat, and m_valid[k] stays high with no bubble.
- Channels are independent. A stalled channel blocks only those input beats addressed to it (head-of-line blocking on the input stream is accepted).
- s_ready is combinational from s_sel, f and m_ready. The producer must hold s_data and s_sel stable while s_valid & ~s_ready.
- Beat ordering is preserved per channel.

## Timing
- Reset (rst_n = 0 at a clk edge): f = 0, d = 0, m_valid = 0, m_data = 0, sel_err = 0, and counters = 0. s_ready evaluates to 1 during and after reset because all buffers are empty.
- Reset mid-operation: buffered beats are discarded, and no m_valid is asserted in the cycle after reset is sampled.
- Latency: a beat accepted at edge t appears on m_valid/m_data immediately after edge t, so the consumer sees it in cycle t+1.
- Throughput: 1 beat/cycle into any channel whose consumer holds m_ready high.
- m_valid[k] never deasserts without a handshake. m_data slice k is stable while m_valid[k] & ~m_ready[k].
- sel_err is high for exactly one cycle per dropped beat. Back-to-back invalid beats give consecutive high cycles.

## Configuration
- Macro STREAM_DEMUX_CNT_EN.
- Defined: adds output port beat_cnt (out, N_CH*16), one 16-bit counter per channel.
  - Each counter increments on every m-side handshake (m_valid[k] & m_ready[k]).
  - Counters wrap 0xFFFF → 0x0000 and reset to 0.
  - Also adds drop_cnt (out, 16), which increments on each invalid-select beat and wraps the same way.
- Undefined: the beat_cnt and drop_cnt ports and their logic are absent. All other behaviour is identical.

## Structure
- Package stream_demux_pkg:
  - CNT_W = 16
  - MAX_CH = 16
  - function sel_valid(sel, n_ch)
- One sub-module, demux_ch_buf: the one-entry buffer with its inputs wr_en, wr_data, rd_ready and outputs valid, data. It includes the optional counter under the same macro. The top instantiates N_CH copies via generate and holds the s_ready mux and the sel_err logic.

## Test plan
- Reset then idle: after rst_n is released, m_valid = 0, s_ready = 1, sel_err = 0. Hold rst_n low at one edge while buffers are full → all m_valid = 0 on the next cycle.
- Steering: N_CH = 4, m_ready = 4'b1111, send sel 0,1,2,3 with data A5,3C,0F,F0 → each appears on its channel one cycle after acceptance, one beat per cycle, with correct slices.
- Backpressure: m_ready[2] = 0, send two beats to channel 2 → the first is accepted and the second sees s_ready = 0. m_data[2] holds its value. When m_ready[2] is raised, the second beat is accepted in the same cycle and m_valid[2] has no bubble.
- Independence: channel 1 is full and stalled, and a beat to channel 3 is accepted immediately with s_ready = 1.
- Invalid select: N_CH = 3, send s_sel = 3 → accepted, sel_err high for exactly one cycle, no m_valid change, drop_cnt = 1 (macro defined).
- Counter wrap (macro defined): preload via 65536 handshakes on channel 0 → beat_cnt[0] returns to 0x0000. With the macro undefined, the build has no counter ports.
